// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// wait counter width and fault classification.
package dm_pkg;

    // Wide enough for the legal wait-state range 0..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'd0,
        FLT_ALIGN = 2'd1,
        FLT_RANGE = 2'd2
    } fault_t;

    // Misaligned byte addresses and word indices past the array both fault.
    function automatic fault_t classify(input logic [31:0] a, input int unsigned depth);
        if (a[1:0] != 2'b00) return FLT_ALIGN;
        if ({2'b00, a[31:2]} >= depth) return FLT_RANGE;
        return FLT_NONE;
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Byte-lane merge for partial stores (sb/sh). Only present when the
// DM_BYTE_LANE_EN macro is defined.
`ifdef DM_BYTE_LANE_EN
module dm_lane_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] new_word
);

    // Each enabled lane takes the store byte; the others keep the old byte.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign new_word[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule
`endif

// File: rtl/dm_responder.sv
// Wait-state data-memory responder for the pipeline's memory stage.
// A request is accepted in IDLE, held for WAIT_CYCLES wait states and
// completed with a one-cycle done pulse in RESP. Optional byte-lane writes
// are enabled by the DM_BYTE_LANE_EN macro; without it every write is a
// full-word write.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] WC = CNT_W'(WAIT_CYCLES);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, load_val;
    logic             accept, enter_resp;

    logic             we_q;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       be_q;
    fault_t           flt_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [31:0]      mem [DEPTH_WORDS];

    // The edge that enters RESP may be the accept edge itself (no wait
    // states), so the operands come straight from the ports in IDLE and
    // from the latched copies otherwise.
    logic             in_idle;
    logic             op_we;
    logic [31:0]      op_addr, op_wdata;
    logic [3:0]       op_be;
    fault_t           op_flt;
    logic [AW-1:0]    op_idx;
    logic [31:0]      old_word, new_word;

    assign in_idle  = (state == IDLE);
    assign op_we    = in_idle ? we    : we_q;
    assign op_addr  = in_idle ? addr  : addr_q;
    assign op_wdata = in_idle ? wdata : wdata_q;
    assign op_be    = in_idle ? be    : be_q;
    assign op_flt   = in_idle ? classify(addr, DEPTH_WORDS) : flt_q;
    assign op_idx   = op_addr[AW+1:2];
    assign old_word = mem[op_idx];

`ifdef DM_BYTE_LANE_EN
    logic null_wr;

    dm_lane_merge u_merge (
        .old_word (old_word),
        .wdata    (op_wdata),
        .be       (op_be),
        .new_word (new_word)
    );

    // A clean write with no lanes enabled changes nothing, so it skips
    // one wait state (it cannot go below a single cycle).
    assign null_wr  = op_we && (op_be == 4'h0) && (op_flt == FLT_NONE);
    assign load_val = (null_wr && WC != '0) ? WC - CNT_W'(1) : WC;
`else
    logic unused_be;

    assign unused_be = ^op_be;
    assign new_word  = op_wdata;
    assign load_val  = WC;
`endif

    // State and wait-counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one cycle of RESP.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (load_val == '0) begin
                        state_n    = RESP;
                        enter_resp = 1'b1;
                        cnt_n      = '0;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = load_val;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_n    = RESP;
                    enter_resp = 1'b1;
                    cnt_n      = '0;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request latch, storage update and response capture. Reset clears the
    // array and drops any in-flight request before it can write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            flt_q   <= FLT_NONE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
                flt_q   <= classify(addr, DEPTH_WORDS);
            end
            if (enter_resp) begin
                err_q   <= (op_flt != FLT_NONE);
                rdata_q <= (op_flt == FLT_NONE && !op_we) ? old_word : 32'h0;
                if (op_flt == FLT_NONE && op_we) mem[op_idx] <= new_word;
            end
        end
    end

    assign ready = in_idle;
    assign busy  = !in_idle || (req && ready);
    assign done  = (state == RESP);
    assign rdata = done ? rdata_q : 32'h0;
    assign err   = done && err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: one instance with two wait
// states and one with none, both with a 64-word array.
module tb_dm_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req0, we0, ready0, done0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  be0;
    logic        req1, we1, ready1, done1, err1, busy1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  be1;

    dm_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .be(be0), .ready(ready0), .done(done0),
        .rdata(rdata0), .err(err0), .busy(busy0)
    );

    dm_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1),
        .wdata(wdata1), .be(be1), .ready(ready1), .done(done1),
        .rdata(rdata1), .err(err1), .busy(busy1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction on the two-wait-state instance; req and operands are
    // scrambled right after the accept edge. Latency counts falling edges
    // from the accept edge to the first one that sees done.
    task automatic x0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int lat, output logic [31:0] rd,
                      output logic e);
        @(negedge clk);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
        @(posedge clk);
        #1;
        req0 = 1'b0; we0 = ~w; addr0 = 32'hFFFF_FFF0; wdata0 = 32'h0BAD_0BAD; be0 = ~b;
        lat = 99; rd = 32'hx; e = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done0) begin
                lat = k; rd = rdata0; e = err0;
                break;
            end
        end
    endtask

    // Same for the zero-wait-state instance.
    task automatic x1(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd);
        @(negedge clk);
        req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = 4'hF;
        @(posedge clk);
        #1;
        req1 = 1'b0; addr1 = 32'hFFFF_FFF0;
        lat = 99; rd = 32'hx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done1) begin
                lat = k; rd = rdata1;
                break;
            end
        end
    endtask

    // Bound the whole run.
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        logic [3:0]  dpat, rpat;
        int          ndone;
        logic [31:0] exp_byte;

`ifdef DM_BYTE_LANE_EN
        exp_byte = 32'hDEAD_BEAA;
`else
        exp_byte = 32'h0000_00AA;
`endif

        reset = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; be1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready0), 32'd1);
        chk("rst_done",  32'(done0),  32'd0);
        chk("rst_err",   32'(err0),   32'd0);
        chk("rst_rdata", rdata0,      32'h0);
        chk("rst_busy",  32'(busy0),  32'd0);
        reset = 1'b1;

        // Full-word write then read-back (req dropped after accept).
        x0(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, e);
        chk("wr_lat", lat, 3);
        chk("wr_err", 32'(e), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done0), 32'd0);
        chk("ready_after", 32'(ready0), 32'd1);
        chk("rdata_idle", rdata0, 32'h0);
        x0(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e);
        chk("rd_lat", lat, 3);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_err", 32'(e), 32'd0);

        // Byte-lane store.
        x0(1'b1, 32'h10, 32'h0000_00AA, 4'h1, lat, rd, e);
        x0(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, e);
        chk("byte_rd", rd, exp_byte);

        // Misaligned read faults.
        x0(1'b0, 32'h13, 32'h0, 4'hF, lat, rd, e);
        chk("align_err", 32'(e), 32'd1);
        chk("align_rdata", rd, 32'h0);
        chk("align_lat", lat, 3);

        // Out-of-range write faults and leaves storage alone (index 64
        // would alias word 0 if truncated).
        x0(1'b1, 32'h100, 32'h1234_5678, 4'hF, lat, rd, e);
        chk("range_err", 32'(e), 32'd1);
        x0(1'b0, 32'h0, 32'h0, 4'hF, lat, rd, e);
        chk("range_w0", rd, 32'h0);
        x0(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, e);
        chk("range_w10", rd, exp_byte);

        // Write with no byte enables.
        x0(1'b1, 32'h14, 32'h0000_0055, 4'h0, lat, rd, e);
        chk("be0_err", 32'(e), 32'd0);
`ifdef DM_BYTE_LANE_EN
        chk("be0_lat", lat, 2);
        x0(1'b0, 32'h14, 32'h0, 4'hF, lat, rd, e);
        chk("be0_rd", rd, 32'h0);
`else
        chk("be0_lat", lat, 3);
        x0(1'b0, 32'h14, 32'h0, 4'hF, lat, rd, e);
        chk("be0_rd", rd, 32'h0000_0055);
`endif

        // Zero wait states, two writes with req held high.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8; wdata1 = 32'h1111_1111; be1 = 4'hF;
        @(posedge clk);
        #1;
        addr1 = 32'hC; wdata1 = 32'h2222_2222;
        dpat = '0; rpat = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dpat[k] = done1;
            rpat[k] = ready1;
            if (k == 2) req1 = 1'b0;
        end
        chk("b2b_done", 32'(dpat), 32'b0101);
        chk("b2b_ready", 32'(rpat), 32'b1010);
        x1(1'b0, 32'h8, 32'h0, lat, rd);
        chk("b2b_lat", lat, 1);
        chk("b2b_rd8", rd, 32'h1111_1111);
        x1(1'b0, 32'hC, 32'h0, lat, rd);
        chk("b2b_rdC", rd, 32'h2222_2222);

        // Reset pulsed while a write is waiting.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hCAFE_F00D; be0 = 4'hF;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy0), 32'd1);
        chk("mid_ready", 32'(ready0), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 32'(ready0), 32'd1);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("post_rst_nodone", ndone, 0);
        x0(1'b0, 32'h20, 32'h0, 4'hF, lat, rd, e);
        chk("post_rst_w20", rd, 32'h0);
        chk("post_rst_lat", lat, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, the wait states inserted before each response (legal range 0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req  input  1  the pipeline data port requests a transaction.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr  input  32  byte address (the ALU result of the memory stage).
REQ-008 SHALL have port wdata  input  32  store data (the forwarded rt value).
REQ-009 SHALL have port be  input  4  byte enables; be[i] selects wdata[8i+7:8i].
REQ-010 SHALL have port ready  output  1  the responder can accept a request this cycle.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  32  read data, valid while done=1.
REQ-013 SHALL have port err  output  1  the completed transaction faulted, valid while done=1.
REQ-014 SHALL have port busy  output  1  a transaction is in flight; the pipeline uses it to drop PC/IF_ID enable.

Function
REQ-015 SHALL use FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive ready=1 only in IDLE, and busy = (state != IDLE) | (req & ready).
REQ-017 SHALL accept on a clock edge in IDLE with req=1, latching we, addr, wdata and be, and loading the wait counter with WAIT_CYCLES.
REQ-018 SHALL go IDLE->WAIT at accept when WAIT_CYCLES>0, and IDLE->RESP when WAIT_CYCLES=0.
REQ-019 SHALL, in WAIT, decrement the counter each edge and enter RESP on the edge where it reaches 0.
REQ-020 SHALL perform the memory write and capture rdata on the edge that enters RESP, so the latency from accept edge to done is exactly WAIT_CYCLES+1 cycles.
REQ-021 SHALL assert done for exactly the one RESP cycle, then return to IDLE; no request is accepted during RESP.
REQ-022 SHALL complete a latched transaction even if req deasserts or addr/wdata change after accept.
REQ-023 SHALL index the word array with addr[31:2]; a read returns the full word regardless of be.
REQ-024 SHALL set err=1 when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS; a faulted transaction performs no write and returns rdata=0.
REQ-025 SHALL hold rdata, done and err at 0 outside the RESP cycle.
REQ-026 SHALL cost exactly one cycle less than a read/write when a write has be=0 and no fault, with the transaction counted complete, memory unchanged and err=0.

Reset
REQ-027 SHALL, while reset=0, force state=IDLE, counter=0, ready=1, done=0, err=0, rdata=0, busy=0, and clear all storage words to 0.
REQ-028 SHALL abort any in-flight transaction when reset asserts mid-transaction: no write occurs and no done is issued afterwards.

Configuration
REQ-029 SHALL, with macro DM_BYTE_LANE_EN defined, write only the bytes selected by be (supports sb/sh).
REQ-030 SHALL, with DM_BYTE_LANE_EN undefined, ignore be and treat any non-faulting write as a full-word write.

Structure
REQ-031 SHALL place the state encodings (IDLE/WAIT/RESP), the WAIT_CYCLES width constant and the fault codes in shared package dm_pkg.
REQ-032 SHALL instantiate one sub-module, dm_lane_merge, which combines the old word, wdata and be into the new word; it is compiled in only under DM_BYTE_LANE_EN.

Verification
REQ-033 SHALL test full-word write, WAIT_CYCLES=2: req, we=1, addr=0x10, wdata=0xDEADBEEF, be=0xF -> done exactly 3 cycles after accept, err=0; a following read of 0x10 returns 0xDEADBEEF.
REQ-034 SHALL test byte-lane write (DM_BYTE_LANE_EN): word 0x10=0xDEADBEEF, then write wdata=0x000000AA, be=0x1 -> read 0x10 returns 0xDEADBEAA; with the macro undefined the read returns 0x000000AA.
REQ-035 SHALL test faults: read of addr=0x13 -> done with err=1, rdata=0; write to addr=DEPTH_WORDS*4 -> err=1 and no storage changed.
REQ-036 SHALL test WAIT_CYCLES=0 back-to-back: req held high for two writes -> done on cycles 1 and 3 after the first accept, ready low in each RESP cycle.
REQ-037 SHALL test reset mid-transaction: a write to 0x20 accepted, reset pulsed low during WAIT -> no done pulse, word 0x20 reads 0, ready=1 right after reset releases.
REQ-038 SHALL test req dropped after accept: req=1 for one cycle with a read of 0x10 -> done still asserted after WAIT_CYCLES+1 cycles with the correct rdata.
